// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: handshaked pipeline stage register with flush, optional skid entry and bubble counter
module pipe_stage_hs #(
  parameter int WIDTH = 32,
  parameter int SKID  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] bubble_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_main, r_skid;
  logic [CNT_W-1:0] r_bubble;
  logic             w_accept, w_consume, w_load_main, w_load_skid, w_from_skid;
  assign out_valid  = r_state != EMPTY;
  assign out_data   = r_main;
  assign occupancy  = r_state;
  assign bubble_cnt = r_bubble;
  // with SKID=0 the ready path sees out_ready; with SKID=1 it depends on state only
  assign in_ready   = !rst && !flush && ((SKID != 0) ? (r_state != TWO) : (!out_valid || out_ready));
  assign w_accept   = in_valid && in_ready;
  assign w_consume  = out_valid && out_ready;
  always_comb begin
    w_load_main = w_accept && (r_state == EMPTY || w_consume);
    w_load_skid = w_accept && r_state == ONE && !w_consume;
    w_from_skid = r_state == TWO && w_consume;
    w_next      = flush ? EMPTY :
                  r_state == EMPTY ? (w_accept ? ONE : EMPTY) :
                  r_state == ONE   ? (w_load_skid ? TWO : (!w_accept && w_consume) ? EMPTY : ONE) :
                  (w_consume ? ONE : TWO);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= EMPTY;
      r_main   <= '0;
      r_skid   <= '0;
      r_bubble <= '0;
    end else begin
      r_state <= w_next;
      if (w_load_main) r_main <= in_data;
      else if (w_from_skid) r_main <= r_skid;
      if (w_load_skid) r_skid <= in_data;
      if (!out_valid && !(&r_bubble)) r_bubble <= r_bubble + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: directed and scoreboarded checks of pipe_stage_hs in SKID=0, SKID=1 and CNT_W=4 builds
module tb_pipe_stage_hs;
  logic        clk = 1'b0;
  logic        rst = 1'b1, flush = 1'b0;
  logic        a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
  logic [31:0] a_in_data = 0, a_out_data;
  logic [1:0]  a_occ;
  logic [15:0] a_bubble;
  logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
  logic [31:0] b_in_data = 0, b_out_data;
  logic [1:0]  b_occ;
  logic [15:0] b_bubble;
  logic        c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
  logic [7:0]  c_in_data = 0, c_out_data;
  logic [1:0]  c_occ;
  logic [3:0]  c_bubble;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  pipe_stage_hs #(.WIDTH(32), .SKID(0), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .bubble_cnt(a_bubble));
  pipe_stage_hs #(.WIDTH(32), .SKID(1), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .bubble_cnt(b_bubble));
  pipe_stage_hs #(.WIDTH(8), .SKID(0), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .occupancy(c_occ), .bubble_cnt(c_bubble));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] qa[$], qb[$];
    logic [31:0] hda, hdb;
    logic        ha, hb;
    int          ea, eb;
    step();
    step();
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_data", a_out_data, 0);
    chk("rst_a_occ", a_occ, 0);
    chk("rst_a_bubble", a_bubble, 0);
    chk("rst_a_ready", a_in_ready, 0);
    chk("rst_b_ready", b_in_ready, 0);
    chk("rst_b_data", b_out_data, 0);
    rst = 0;
    for (int i = 0; i < 10; i++) step();
    chk("bub_c_10", c_bubble, 10);
    for (int i = 0; i < 12; i++) step();
    chk("bub_c_sat", c_bubble, 15);
    chk("bub_a_22", a_bubble, 22);
    a_out_ready = 1;
    a_in_valid = 1;
    a_in_data = 32'h11;
    #1 chk("t1_ready0", a_in_ready, 1);
    step();
    chk("t1_v11", a_out_valid, 1);
    chk("t1_d11", a_out_data, 32'h11);
    a_in_data = 32'h22;
    #1 chk("t1_ready1", a_in_ready, 1);
    step();
    chk("t1_d22", a_out_data, 32'h22);
    a_in_data = 32'h33;
    #1 chk("t1_ready2", a_in_ready, 1);
    step();
    chk("t1_d33", a_out_data, 32'h33);
    a_in_valid = 0;
    step();
    chk("t1_drain", a_out_valid, 0);
    chk("t1_bubble", a_bubble, 23);
    b_in_valid = 1;
    b_in_data = 32'hA;
    step();
    chk("t2_occ1", b_occ, 1);
    b_in_data = 32'hB;
    step();
    b_in_valid = 0;
    chk("t2_occ2", b_occ, 2);
    chk("t2_ready", b_in_ready, 0);
    chk("t2_hold", b_out_data, 32'hA);
    b_out_ready = 1;
    #1 chk("t2_ready_regd", b_in_ready, 0);
    step();
    chk("t2_dB", b_out_data, 32'hB);
    chk("t2_occ_21", b_occ, 1);
    step();
    chk("t2_occ_0", b_occ, 0);
    chk("t2_empty", b_out_valid, 0);
    b_out_ready = 0;
    b_in_valid = 1;
    b_in_data = 32'h1;
    step();
    b_in_data = 32'h2;
    step();
    chk("t3_two", b_occ, 2);
    flush = 1;
    b_in_data = 32'hC;
    #1 chk("t3_ready", b_in_ready, 0);
    step();
    flush = 0;
    b_in_valid = 0;
    b_out_ready = 1;
    chk("t3_valid", b_out_valid, 0);
    chk("t3_occ", b_occ, 0);
    step();
    chk("t3_noC", b_out_valid, 0);
    b_out_ready = 0;
    a_out_ready = 0;
    a_in_valid = 1;
    a_in_data = 32'h55;
    step();
    a_in_valid = 0;
    chk("t4_occ1", a_occ, 1);
    chk("t4_d55", a_out_data, 32'h55);
    rst = 1;
    #1 chk("t4_rst_ready", a_in_ready, 0);
    step();
    rst = 0;
    chk("t4_valid", a_out_valid, 0);
    chk("t4_data", a_out_data, 0);
    chk("t4_bubble", a_bubble, 0);
    chk("t4_occ", a_occ, 0);
    a_in_valid = 1;
    step();
    a_in_valid = 0;
    chk("t4_reload", a_out_data, 32'h55);
    rst = 1;
    flush = 1;
    step();
    rst = 0;
    flush = 0;
    chk("t4f_valid", a_out_valid, 0);
    chk("t4f_data", a_out_data, 0);
    chk("t4f_bubble", a_bubble, 0);
    ea = 0;
    eb = 0;
    ha = 0;
    hb = 0;
    hda = 0;
    hdb = 0;
    for (int i = 0; i < 10000; i++) begin
      a_in_valid = 1'($urandom_range(0, 1));
      a_out_ready = 1'($urandom_range(0, 1));
      a_in_data = $urandom;
      b_in_valid = 1'($urandom_range(0, 1));
      b_out_ready = 1'($urandom_range(0, 1));
      b_in_data = $urandom;
      #1;
      if (a_in_ready !== (!a_out_valid || a_out_ready)) ea++;
      if (b_in_ready !== (b_occ != 2'd2)) eb++;
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0 || a_out_data !== qa[0]) ea++;
        if (qa.size() != 0) void'(qa.pop_front());
      end
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0 || b_out_data !== qb[0]) eb++;
        if (qb.size() != 0) void'(qb.pop_front());
      end
      if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
      if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
      ha = a_out_valid && !a_out_ready;
      hda = a_out_data;
      hb = b_out_valid && !b_out_ready;
      hdb = b_out_data;
      step();
      if (ha && (!a_out_valid || a_out_data !== hda)) ea++;
      if (hb && (!b_out_valid || b_out_data !== hdb)) eb++;
      if (int'(a_occ) != qa.size() || a_out_valid != (qa.size() != 0)) ea++;
      if (int'(b_occ) != qb.size() || b_out_valid != (qb.size() != 0)) eb++;
    end
    chk("rand_a_errs", 64'(ea), 0);
    chk("rand_b_errs", 64'(eb), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
